// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module      : alu_req_arbiter
// Description : Round-robin arbiter/sequencer sharing one combinational ALU
//               between two requesters; returns tagged result and flags.
//               Optional completed-operation counters: ALU_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_req_arbiter #(
    parameter int WIDTH = 8,
    parameter int SH_W  = 4,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SH_W-1:0]  req0_shift,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SH_W-1:0]  req1_shift,
    input  logic [OP_W-1:0]  req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SH_W-1:0]  alu_shift,
    output logic [OP_W-1:0]  alu_s,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic [2:0]       rsp_flags,
    output logic             busy,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant;
    logic   accept;

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid && !grant;
                    req1_ready = req1_valid && grant;
                end
                accept = req0_ready || req1_ready;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_shift  <= '0;
            alu_s      <= '0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_flags  <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                alu_a      <= grant ? req1_a     : req0_a;
                alu_b      <= grant ? req1_b     : req0_b;
                alu_shift  <= grant ? req1_shift : req0_shift;
                alu_s      <= grant ? req1_op    : req0_op;
                rsp_id     <= grant;
                last_grant <= grant;
            end
            // ALU has had the full EXEC cycle to settle from the registered operands.
            if (state == EXEC) begin
                rsp_y     <= alu_y;
                rsp_flags <= {alu_overflow, alu_carry, alu_zero};
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= 16'h0000;
            cnt1 <= 16'h0000;
        end else if (rsp_valid && rsp_ready) begin
            if (!rsp_id && (cnt0 != 16'hFFFF)) begin
                cnt0 <= cnt0 + 16'h0001;
            end
            if (rsp_id && (cnt1 != 16'hFFFF)) begin
                cnt1 <= cnt1 + 16'h0001;
            end
        end
    end
`else
    assign cnt0 = 16'h0000;
    assign cnt1 = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Scoreboard bench for alu_req_arbiter with a small ALU model.
//               Stats expectations follow ALU_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_req_arbiter;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sh;
        logic [2:0] op;
    } op_t;

    typedef struct packed {
        logic       id;
        logic [7:0] y;
        logic [2:0] fl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_shift, req1_shift;
    logic [2:0] req0_op, req1_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [3:0] alu_shift;
    logic [2:0] alu_s;
    logic       alu_zero, alu_carry, alu_overflow;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_y;
    logic [2:0] rsp_flags;
    logic       busy;
    logic [15:0] cnt0, cnt1;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int hs_edge = 0;
    bit drv_en = 0;
    bit quick = 0;

    alu_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shift(alu_shift), .alu_s(alu_s),
        .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // ALU model: 0 add, 1 sub (carry = borrow), 2 and, 3 shift left.
    logic [8:0] m_sum, m_dif;
    logic [7:0] m_y;
    logic       m_c, m_v;
    always_comb begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_dif = {1'b0, alu_a} - {1'b0, alu_b};
        m_y   = alu_a;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_s)
            3'd0: begin
                {m_c, m_y} = m_sum;
                m_v = (alu_a[7] == alu_b[7]) && (m_y[7] != alu_a[7]);
            end
            3'd1: begin
                {m_c, m_y} = m_dif;
                m_v = (alu_a[7] != alu_b[7]) && (m_y[7] != alu_a[7]);
            end
            3'd2: m_y = alu_a & alu_b;
            3'd3: m_y = alu_a << alu_shift;
            default: m_y = alu_a;
        endcase
    end
    assign alu_y        = m_y;
    assign alu_zero     = (m_y == 8'h00);
    assign alu_carry    = m_c;
    assign alu_overflow = m_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !rsp_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got q0=%0d q1=%0d sb=%0d expected all 0", q0.size(), q1.size(), sb.size());
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got rsp_valid=0 expected 1");
    endtask

    function automatic op_t mk(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] sh, input logic [2:0] op);
        op_t o;
        o.a = a; o.b = b; o.sh = sh; o.op = op;
        return o;
    endfunction

    function automatic exp_t mx(input logic id, input logic [7:0] y, input logic [2:0] fl);
        exp_t e;
        e.id = id; e.y = y; e.fl = fl;
        return e;
    endfunction

    // Driver: presents the head of each requester queue.
    initial begin
        forever begin
            tick();
            if (drv_en) begin
                req0_valid = (q0.size() > 0);
                if (q0.size() > 0) begin
                    req0_a = q0[0].a; req0_b = q0[0].b; req0_shift = q0[0].sh; req0_op = q0[0].op;
                end
                req1_valid = (q1.size() > 0);
                if (q1.size() > 0) begin
                    req1_a = q1[0].a; req1_b = q1[0].b; req1_shift = q1[0].sh; req1_op = q1[0].op;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Accept tracker: the handshake completes at the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
                last_acc = cyc + 1;
                if (req0_valid && req0_ready) void'(q0.pop_front());
                else void'(q1.pop_front());
                if (quick) begin
                    check("accept_after_rsp", last_acc, hs_edge + 1);
                    quick = 0;
                end
            end
        end
    end

    // Monitor: latency, stability under backpressure, scoreboard compare.
    initial begin
        bit         prev_v = 0;
        bit         held = 0;
        logic       h_id;
        logic [7:0] h_y;
        logic [2:0] h_fl;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (!prev_v && !rst) check("rsp_latency", cyc, last_acc + 1);
                if (!rsp_ready) begin
                    if (held) begin
                        check("hold_y", rsp_y, h_y);
                        check("hold_flags", rsp_flags, h_fl);
                        check("hold_id", rsp_id, h_id);
                    end else begin
                        held = 1; h_id = rsp_id; h_y = rsp_y; h_fl = rsp_flags;
                    end
                    check("ready_low_resp", {req0_ready, req1_ready}, 2'b00);
                end else if (!rst) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id=%0d y=%0h expected none", rsp_id, rsp_y);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_y", rsp_y, e.y);
                        check("rsp_flags", rsp_flags, e.fl);
                    end
                    hs_edge = cyc + 1;
                    held = 0;
                end
            end else begin
                held = 0;
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        rst = 1; rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        req0_a = 0; req0_b = 0; req0_shift = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_shift = 0; req1_op = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {req0_ready, req1_ready}, 2'b00);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_alu", {alu_a, alu_b, alu_shift, alu_s}, 0);
        check("reset_rsp", {rsp_id, rsp_y, rsp_flags}, 0);
        check("reset_cnt", {cnt0, cnt1}, 0);
        tick();
        rst = 0; req0_valid = 0; req1_valid = 0; drv_en = 1;

        // Contention straight after reset: req0 first, then alternating.
        @(negedge clk);
        q0.push_back(mk(8'h03, 8'h04, 4'd0, 3'd0));
        q0.push_back(mk(8'h7F, 8'h01, 4'd0, 3'd0));
        q1.push_back(mk(8'hFF, 8'h01, 4'd0, 3'd0));
        q1.push_back(mk(8'h01, 8'h00, 4'd3, 3'd3));
        sb.push_back(mx(1'b0, 8'h07, 3'b000));
        sb.push_back(mx(1'b1, 8'h00, 3'b011));
        sb.push_back(mx(1'b0, 8'h80, 3'b100));
        sb.push_back(mx(1'b1, 8'h08, 3'b000));
        wait_drain();

        // Single op from req0.
        q0.push_back(mk(8'h0F, 8'h01, 4'd0, 3'd0));
        sb.push_back(mx(1'b0, 8'h10, 3'b000));
        wait_drain();

        // Backpressure with both requesters pending; last grant was 0.
        tick();
        rsp_ready = 0;
        @(negedge clk);
        q1.push_back(mk(8'h05, 8'h07, 4'd0, 3'd1));
        q0.push_back(mk(8'hF0, 8'h0F, 4'd0, 3'd2));
        sb.push_back(mx(1'b1, 8'hFE, 3'b010));
        sb.push_back(mx(1'b0, 8'h00, 3'b001));
        wait_rsp();
        repeat (5) tick();
        quick = 1;
        rsp_ready = 1;
        wait_drain();
        check("quick_accept_seen", quick, 0);

        @(negedge clk);
`ifdef ALU_ARB_STATS_EN
        check("cnt0", cnt0, 16'd4);
        check("cnt1", cnt1, 16'd3);
`else
        check("cnt0", cnt0, 16'd0);
        check("cnt1", cnt1, 16'd0);
`endif

        // Reset while a response is pending: it must be discarded.
        tick();
        rsp_ready = 0;
        @(negedge clk);
        q0.push_back(mk(8'h11, 8'h22, 4'd5, 3'd0));
        wait_rsp();
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_alu", {alu_a, alu_b, alu_shift, alu_s}, 0);
        check("rstmid_rsp", {rsp_id, rsp_y, rsp_flags}, 0);
        check("rstmid_cnt", {cnt0, cnt1}, 0);
        tick();
        rsp_ready = 1;

        // After reset req0 again wins the first contention.
        @(negedge clk);
        q1.push_back(mk(8'h01, 8'h01, 4'd0, 3'd0));
        q0.push_back(mk(8'hAA, 8'h0F, 4'd0, 3'd2));
        sb.push_back(mx(1'b0, 8'h0A, 3'b000));
        sb.push_back(mx(1'b1, 8'h02, 3'b000));
        wait_drain();
        @(negedge clk);
        check("alu_hold_after_done", {alu_a, alu_b, alu_s}, {8'h01, 8'h01, 3'd0});
`ifdef ALU_ARB_STATS_EN
        check("cnt_after_rst", {cnt0, cnt1}, {16'd1, 16'd1});
`else
        check("cnt_after_rst", {cnt0, cnt1}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
